// File: rtl/regfile_gen2_pkg.sv
// Shared defaults for the gen2 register file: bus/select widths, special-register indices, reset values.
package regfile_gen2_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned PC_IDX_DEF = 7;
  localparam int unsigned SP_IDX_DEF = 6;

  localparam logic [DATA_W_DEF-1:0] PC_RST_DEF = 8'h00;
  localparam logic [DATA_W_DEF-1:0] SP_TOP_DEF = 8'hFF;
  localparam logic [DATA_W_DEF-1:0] SP_BOT_DEF = 8'hF0;

endpackage

// File: rtl/regfile_gen2_read_port.sv
// One asynchronous read port: select 0 returns external data, optional same-cycle write forwarding.
module rf_read_port #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter bit          BYPASS = 1'b0
) (
  input  logic [ADDR_W-1:0] sel_i,
  input  logic [ADDR_W-1:0] wsel_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic [DATA_W-1:0] regs_i [1:(2**ADDR_W)-1],
  output logic [DATA_W-1:0] data_o
);

  // A nonzero match on the write select implies a live write, so no extra qualifier is needed.
  always_comb begin
    data_o = din_i;
    if (sel_i != '0) begin
      if (BYPASS && (sel_i == wsel_i)) begin
        data_o = wdata_i;
      end else begin
        data_o = regs_i[sel_i];
      end
    end
  end

endmodule

// File: rtl/regfile_gen2.sv
// CPU register file: one write port, two async read ports, PC auto-increment and SP push/pop with sticky flags.
module regfile_gen2
  import regfile_gen2_pkg::*;
#(
  parameter int unsigned       DATA_W = DATA_W_DEF,
  parameter int unsigned       ADDR_W = ADDR_W_DEF,
  parameter int unsigned       PC_IDX = PC_IDX_DEF,
  parameter int unsigned       SP_IDX = SP_IDX_DEF,
  parameter logic [DATA_W-1:0] PC_RST = DATA_W'(PC_RST_DEF),
  parameter logic [DATA_W-1:0] SP_TOP = DATA_W'(SP_TOP_DEF),
  parameter logic [DATA_W-1:0] SP_BOT = DATA_W'(SP_BOT_DEF),
  parameter bit                BYPASS = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] dsel_i,
  input  logic [DATA_W-1:0] rin_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic [ADDR_W-1:0] asel_i,
  input  logic [ADDR_W-1:0] bsel_i,
  input  logic              pc_inc_i,
  input  logic              sp_push_i,
  input  logic              sp_pop_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [DATA_W-1:0] pc_out_o,
  output logic [DATA_W-1:0] sp_out_o,
  output logic              sp_ovf_o,
  output logic              sp_unf_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_SEL = ADDR_W'(PC_IDX);
  localparam logic [ADDR_W-1:0] SP_SEL = ADDR_W'(SP_IDX);

  if ((PC_IDX == SP_IDX) || (PC_IDX == 0) || (SP_IDX == 0) ||
      (PC_IDX >= DEPTH) || (SP_IDX >= DEPTH)) begin : g_bad_idx
    $error("regfile_gen2: PC_IDX/SP_IDX must be distinct, nonzero and below DEPTH");
  end

  logic [DATA_W-1:0] regs_q [1:DEPTH-1];
  logic [DATA_W-1:0] regs_d [1:DEPTH-1];
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [DATA_W-1:0] pc_q, sp_q;

  assign pc_q = regs_q[PC_IDX];
  assign sp_q = regs_q[SP_IDX];

  // Explicit writes take priority over PC increment and SP push/pop.
  always_comb begin
    regs_d = regs_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (dsel_i != '0) begin
      regs_d[dsel_i] = rin_i;
    end
    if (pc_inc_i && (dsel_i != PC_SEL)) begin
      regs_d[PC_IDX] = pc_q + DATA_W'(1);
    end
    if (dsel_i == SP_SEL) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (sp_push_i && !sp_pop_i) begin
      if (sp_q == SP_BOT) begin
        ovf_d = 1'b1;
      end else begin
        regs_d[SP_IDX] = sp_q - DATA_W'(1);
      end
    end else if (sp_pop_i && !sp_push_i) begin
      if (sp_q == SP_TOP) begin
        unf_d = 1'b1;
      end else begin
        regs_d[SP_IDX] = sp_q + DATA_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        regs_q[i] <= (i == PC_IDX) ? PC_RST : ((i == SP_IDX) ? SP_TOP : '0);
      end
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign pc_out_o = pc_q;
  assign sp_out_o = sp_q;
  assign sp_ovf_o = ovf_q;
  assign sp_unf_o = unf_q;

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_a (
    .sel_i   (asel_i),
    .wsel_i  (dsel_i),
    .wdata_i (rin_i),
    .din_i   (din_i),
    .regs_i  (regs_q),
    .data_o  (a_o)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_b (
    .sel_i   (bsel_i),
    .wsel_i  (dsel_i),
    .wdata_i (rin_i),
    .din_i   (din_i),
    .regs_i  (regs_q),
    .data_o  (b_o)
  );

endmodule

// File: tb/tb_regfile_gen2.sv
// Bench for regfile_gen2: directed scenarios plus randomized traffic against a behavioural model (BYPASS=0 and 1).
module tb_regfile_gen2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dsel = '0, asel = '0, bsel = '0;
  logic [7:0] rin = '0, din = '0;
  logic       pc_inc = 1'b0, sp_push = 1'b0, sp_pop = 1'b0;

  logic [7:0] a0, b0, pc0, sp0, a1, b1, pc1, sp1;
  logic       ovf0, unf0, ovf1, unf1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_r [8];
  logic       m_ovf = 1'b0, m_unf = 1'b0;

  always #5 clk = ~clk;

  regfile_gen2 #(.BYPASS(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .dsel_i(dsel), .rin_i(rin), .din_i(din),
    .asel_i(asel), .bsel_i(bsel), .pc_inc_i(pc_inc), .sp_push_i(sp_push), .sp_pop_i(sp_pop),
    .a_o(a0), .b_o(b0), .pc_out_o(pc0), .sp_out_o(sp0), .sp_ovf_o(ovf0), .sp_unf_o(unf0)
  );

  regfile_gen2 #(.BYPASS(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .dsel_i(dsel), .rin_i(rin), .din_i(din),
    .asel_i(asel), .bsel_i(bsel), .pc_inc_i(pc_inc), .sp_push_i(sp_push), .sp_pop_i(sp_pop),
    .a_o(a1), .b_o(b1), .pc_out_o(pc1), .sp_out_o(sp1), .sp_ovf_o(ovf1), .sp_unf_o(unf1)
  );

  // Reference behaviour of one clock edge, written from the register-file rules.
  task automatic model_edge();
    logic [7:0] nr [8];
    nr = m_r;
    if (rst) begin
      for (int i = 0; i < 8; i++) nr[i] = 8'h00;
      nr[6] = 8'hFF;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (dsel != 0) nr[dsel] = rin;
      if (pc_inc && dsel != 3'd7) nr[7] = 8'((int'(m_r[7]) + 1) % 256);
      if (dsel == 3'd6) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end else if (sp_push && !sp_pop) begin
        if (m_r[6] == 8'hF0) m_ovf = 1'b1;
        else nr[6] = m_r[6] - 8'd1;
      end else if (sp_pop && !sp_push) begin
        if (m_r[6] == 8'hFF) m_unf = 1'b1;
        else nr[6] = m_r[6] + 8'd1;
      end
    end
    m_r = nr;
  endtask

  function automatic logic [7:0] model_read(input logic [2:0] sel, input bit bypass);
    if (sel == 0) return din;
    if (bypass && sel == dsel) return rin;
    return m_r[sel];
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; asel = 3'd7; bsel = 3'd6; din = 8'h5A;
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (a0 !== 8'h00) begin n_fail++; $display("FAIL reset_pc_read: got %h want 00", a0); end
    n_checks++;
    if (b0 !== 8'hFF) begin n_fail++; $display("FAIL reset_sp_read: got %h want ff", b0); end
    n_checks++;
    if ({ovf0, unf0, ovf1, unf1} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {ovf0, unf0, ovf1, unf1});
    end
    asel = 3'd0;
    #1;
    n_checks++;
    if (a0 !== 8'h5A) begin n_fail++; $display("FAIL reset_din_read: got %h want 5a", a0); end
  endtask

  task automatic test_write_latency();
    dsel = 3'd3; rin = 8'hC3; asel = 3'd3; bsel = 3'd3;
    #1;
    n_checks++;
    if ({a0, b0} !== 16'h0000) begin n_fail++; $display("FAIL write_same_cycle_nobyp: got %h want 0000", {a0, b0}); end
    n_checks++;
    if ({a1, b1} !== 16'hC3C3) begin n_fail++; $display("FAIL write_same_cycle_byp: got %h want c3c3", {a1, b1}); end
    step();
    dsel = 3'd0;
    #1;
    n_checks++;
    if ({a0, b0, a1, b1} !== 32'hC3C3C3C3) begin
      n_fail++; $display("FAIL write_next_cycle: got %h want c3c3c3c3", {a0, b0, a1, b1});
    end
  endtask

  task automatic test_pc();
    dsel = 3'd7; rin = 8'hFE;
    step();
    dsel = 3'd0; pc_inc = 1'b1;
    step();
    n_checks++;
    if (pc0 !== 8'hFF) begin n_fail++; $display("FAIL pc_inc_ff: got %h want ff", pc0); end
    step();
    n_checks++;
    if (pc0 !== 8'h00) begin n_fail++; $display("FAIL pc_wrap: got %h want 00", pc0); end
    dsel = 3'd7; rin = 8'h40;
    step();
    n_checks++;
    if (pc0 !== 8'h40) begin n_fail++; $display("FAIL pc_write_wins: got %h want 40", pc0); end
    dsel = 3'd0; pc_inc = 1'b0;
  endtask

  task automatic test_stack();
    sp_push = 1'b1;
    for (int i = 0; i < 15; i++) step();
    n_checks++;
    if ({sp0, ovf0} !== {8'hF0, 1'b0}) begin n_fail++; $display("FAIL push15: got sp=%h ovf=%b want f0/0", sp0, ovf0); end
    step();
    n_checks++;
    if ({sp0, ovf0} !== {8'hF0, 1'b1}) begin n_fail++; $display("FAIL push_overflow: got sp=%h ovf=%b want f0/1", sp0, ovf0); end
    sp_pop = 1'b1;
    step();
    n_checks++;
    if ({sp0, ovf0} !== {8'hF0, 1'b1}) begin n_fail++; $display("FAIL push_pop_same: got sp=%h ovf=%b want f0/1", sp0, ovf0); end
    sp_push = 1'b0; sp_pop = 1'b0; dsel = 3'd6; rin = 8'hFF;
    step();
    dsel = 3'd0; sp_pop = 1'b1;
    step();
    n_checks++;
    if ({sp0, unf0, ovf0} !== {8'hFF, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL pop_underflow: got sp=%h unf=%b ovf=%b want ff/1/0", sp0, unf0, ovf0);
    end
    sp_pop = 1'b0; dsel = 3'd6; rin = 8'h80;
    step();
    dsel = 3'd0;
    n_checks++;
    if ({sp0, unf0} !== {8'h80, 1'b0}) begin n_fail++; $display("FAIL sp_write_clear: got sp=%h unf=%b want 80/0", sp0, unf0); end
  endtask

  task automatic test_reset_override();
    dsel = 3'd3; rin = 8'hAA; pc_inc = 1'b1; sp_push = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; dsel = 3'd0; pc_inc = 1'b0; sp_push = 1'b0; asel = 3'd3;
    #1;
    n_checks++;
    if ({pc0, sp0, a0, ovf0, unf0} !== {8'h00, 8'hFF, 8'h00, 2'b00}) begin
      n_fail++; $display("FAIL reset_override: got pc=%h sp=%h r3=%h flags=%b%b want 00/ff/00/00", pc0, sp0, a0, ovf0, unf0);
    end
  endtask

  task automatic test_random();
    logic [7:0] ea0, eb0, ea1, eb1;
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(0, 59) == 0);
      dsel    = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0;
      rin     = 8'($urandom);
      din     = 8'($urandom);
      asel    = 3'($urandom);
      bsel    = ($urandom_range(0, 3) == 0) ? asel : 3'($urandom);
      pc_inc  = 1'($urandom);
      sp_push = ($urandom_range(0, 9) < 6);
      sp_pop  = ($urandom_range(0, 9) < 4);
      #1;
      ea0 = model_read(asel, 1'b0); eb0 = model_read(bsel, 1'b0);
      ea1 = model_read(asel, 1'b1); eb1 = model_read(bsel, 1'b1);
      n_checks++;
      if ({a0, b0, a1, b1} !== {ea0, eb0, ea1, eb1}) begin
        n_fail++; $display("FAIL rand_read[%0d]: got %h want %h", n, {a0, b0, a1, b1}, {ea0, eb0, ea1, eb1});
      end
      step();
      n_checks++;
      if ({pc0, sp0, ovf0, unf0, pc1, sp1, ovf1, unf1} !== {m_r[7], m_r[6], m_ovf, m_unf, m_r[7], m_r[6], m_ovf, m_unf}) begin
        n_fail++; $display("FAIL rand_state[%0d]: got pc=%h sp=%h ovf=%b unf=%b want pc=%h sp=%h ovf=%b unf=%b",
                           n, pc0, sp0, ovf0, unf0, m_r[7], m_r[6], m_ovf, m_unf);
      end
    end
    rst = 1'b0; dsel = '0; pc_inc = 1'b0; sp_push = 1'b0; sp_pop = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    test_reset();
    test_write_latency();
    test_pc();
    test_stack();
    test_reset_override();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
